// File: rtl/store_write_unit.sv
// Store write unit: lane-places MEM-stage stores, buffers them in a small FIFO and
// drains them to the data-memory port over req/ack. Optional macro STORE_ALIGN_CHECK_EN.
module store_write_unit #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  storeType,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  output logic        busy,
  output logic        st_exc
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  be_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [PTR_W:0]   count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_byteen_q, mem_byteen_d;

  logic        is_sb, is_sh, is_sw, full, accept, enq, pop;
  logic [1:0]  off;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_be;

  assign full     = (count_q == FULL_CNT);
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign off      = st_addr[1:0];
  assign head_nxt = head_q + PTR_W'(1);
  assign pop      = (state_q == REQ) && mem_ack;

  always_comb begin
    is_sb   = storeType[2];
    is_sh   = !storeType[2] && storeType[1];
    is_sw   = (storeType[2:1] == 2'b00) && storeType[0];
    in_addr = {st_addr[31:2], 2'b00};
    in_data = st_wdata;
    in_be   = 4'b0000;
    if (is_sb) begin
      in_be   = 4'b0001 << off;
      in_data = {4{st_wdata[7:0]}};
    end else if (is_sh) begin
      in_be   = 4'b0011 << {off[1], 1'b0};
      in_data = {2{st_wdata[15:0]}};
    end else if (is_sw) begin
      in_be   = 4'b1111;
    end
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misalign, st_exc_q;
  assign misalign = (is_sh && off[0]) || (is_sw && (off != 2'b00));
  assign enq      = accept && (is_sb || is_sh || is_sw) && !misalign;
  assign st_exc   = st_exc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_exc_q <= 1'b0;
    else       st_exc_q <= accept && misalign;
  end
`else
  assign enq    = accept && (is_sb || is_sh || is_sw);
  assign st_exc = 1'b0;
`endif

  // Entry storage needs no reset: validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
      be_mem[tail_q]   <= in_be;
    end
  end

  always_comb begin
    head_d       = pop ? head_nxt : head_q;
    tail_d       = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d      = count_q;
    if (enq && !pop)      count_d = count_q + ONE_CNT;
    else if (!enq && pop) count_d = count_q - ONE_CNT;
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_byteen_d = mem_byteen_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_req_d    = 1'b1;
          mem_addr_d   = addr_mem[head_q];
          mem_wdata_d  = data_mem[head_q];
          mem_byteen_d = be_mem[head_q];
          state_d      = REQ;
        end
      end
      default: begin
        // The in-flight store stays counted until acked; the next head may be
        // the entry being written this very edge, so bypass it from the input.
        if (mem_ack) begin
          if (count_q > ONE_CNT) begin
            mem_addr_d   = addr_mem[head_nxt];
            mem_wdata_d  = data_mem[head_nxt];
            mem_byteen_d = be_mem[head_nxt];
          end else if (enq) begin
            mem_addr_d   = in_addr;
            mem_wdata_d  = in_data;
            mem_byteen_d = in_be;
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_byteen_q <= mem_byteen_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_byteen = mem_byteen_q;
  assign busy       = (count_q != '0) || mem_req_q;
endmodule

// File: tb/tb_store_write_unit.sv
// Directed bench for store_write_unit: lane placement, FIFO fill/drain, back-to-back
// requests, same-edge enqueue+pop, reset mid-transaction and the misaligned-store path.
module tb_store_write_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic [2:0]  storeType = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        st_exc;

  int checks = 0;
  int errors = 0;

  store_write_unit #(.DEPTH(2), .PTR_W(1)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_wdata(st_wdata), .storeType(storeType),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_ack(mem_ack), .busy(busy), .st_exc(st_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid  = v;
    storeType = t;
    st_addr   = a;
    st_wdata  = d;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_byteen), 32'h0);
    chk("rst_exc", 32'(st_exc), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(st_ready), 32'd1);

    // sb at offset 3
    drive(1'b1, 3'b100, 32'h0000_1003, 32'h1234_56AB);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("sb_req_n1", 32'(mem_req), 32'd0);
    chk("sb_busy_n1", 32'(busy), 32'd1);
    tick();
    chk("sb_req", 32'(mem_req), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_be", 32'(mem_byteen), 32'b1000);
    chk("sb_data", mem_wdata, 32'hABAB_ABAB);
    tick();
    chk("sb_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_done_req", 32'(mem_req), 32'd0);
    chk("sb_done_busy", 32'(busy), 32'd0);

    // sh then sw, back-to-back drain
    drive(1'b1, 3'b010, 32'h0000_2002, 32'hFFFF_BEEF);
    tick();
    drive(1'b1, 3'b001, 32'h0000_2004, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("sh_req", 32'(mem_req), 32'd1);
    chk("sh_addr", mem_addr, 32'h0000_2000);
    chk("sh_be", 32'(mem_byteen), 32'b1100);
    chk("sh_data", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_full", 32'(st_ready), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_addr", mem_addr, 32'h0000_2004);
    chk("sw_be", 32'(mem_byteen), 32'b1111);
    chk("sw_data", mem_wdata, 32'hCAFE_F00D);
    chk("sw_ready", 32'(st_ready), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sw_done_req", 32'(mem_req), 32'd0);
    chk("sw_done_busy", 32'(busy), 32'd0);

    // Three stores with ack low: the third waits on a full buffer
    drive(1'b1, 3'b001, 32'h0000_0100, 32'h1);
    tick();
    chk("f3_ready1", 32'(st_ready), 32'd1);
    drive(1'b1, 3'b001, 32'h0000_0104, 32'h2);
    tick();
    chk("f3_ready2", 32'(st_ready), 32'd0);
    drive(1'b1, 3'b001, 32'h0000_0108, 32'h3);
    tick();
    chk("f3_ready3", 32'(st_ready), 32'd0);
    chk("f3_addr_a", mem_addr, 32'h0000_0100);
    tick();
    chk("f3_req_hold", 32'(mem_req), 32'd1);
    chk("f3_addr_b", mem_addr, 32'h0000_0100);
    mem_ack = 1'b1;
    tick();
    // Pop while full: third store still not taken
    chk("f3_req2", 32'(mem_req), 32'd1);
    chk("f3_addr2", mem_addr, 32'h0000_0104);
    chk("f3_ready4", 32'(st_ready), 32'd1);
    tick();
    // Enqueue and ack on the same edge with count=1
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("f3_req3", 32'(mem_req), 32'd1);
    chk("f3_addr3", mem_addr, 32'h0000_0108);
    chk("f3_data3", mem_wdata, 32'h3);
    chk("f3_busy3", 32'(busy), 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("f3_done_req", 32'(mem_req), 32'd0);
    chk("f3_done_busy", 32'(busy), 32'd0);

    // Reset while in REQ with two entries
    drive(1'b1, 3'b001, 32'h0000_0200, 32'hA);
    tick();
    drive(1'b1, 3'b001, 32'h0000_0204, 32'hB);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("mr_req_pre", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(st_ready), 32'd1);
    tick();
    reset = 1'b0;
    drive(1'b1, 3'b001, 32'h0000_0300, 32'h55);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    chk("mr_new_req", 32'(mem_req), 32'd1);
    chk("mr_new_addr", mem_addr, 32'h0000_0300);
    chk("mr_new_data", mem_wdata, 32'h55);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("mr_new_done", 32'(mem_req), 32'd0);

    // storeType==0 is consumed without enqueue
    drive(1'b1, 3'b000, 32'h0000_0400, 32'h99);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("nop_busy", 32'(busy), 32'd0);
    tick();
    chk("nop_req", 32'(mem_req), 32'd0);

    // sb at offset 1
    drive(1'b1, 3'b100, 32'h0000_4001, 32'h0000_005A);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    chk("sb1_be", 32'(mem_byteen), 32'b0010);
    chk("sb1_data", mem_wdata, 32'h5A5A_5A5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Misaligned sw
    drive(1'b1, 3'b001, 32'h0000_3001, 32'h77);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
`ifdef STORE_ALIGN_CHECK_EN
    chk("mis_exc", 32'(st_exc), 32'd1);
    chk("mis_busy", 32'(busy), 32'd0);
    tick();
    chk("mis_exc_clr", 32'(st_exc), 32'd0);
    chk("mis_req", 32'(mem_req), 32'd0);
`else
    chk("mis_exc", 32'(st_exc), 32'd0);
    chk("mis_busy", 32'(busy), 32'd1);
    tick();
    chk("mis_req", 32'(mem_req), 32'd1);
    chk("mis_addr", mem_addr, 32'h0000_3000);
    chk("mis_be", 32'(mem_byteen), 32'b1111);
    chk("mis_data", mem_wdata, 32'h77);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("mis_done", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
